// File: rtl/program_loader_pkg.sv
// rtl/program_loader_pkg.sv - shared types and constants for the UART program loader
package program_loader_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PSIZE,
    S_PWORD,
    S_DSIZE,
    S_DWORD,
    S_DWAIT,
    S_DONE
  } state_e;

  typedef logic [31:0] word_t;

  localparam int unsigned BYTES_PER_WORD = 4;

endpackage

// File: rtl/program_loader_byte_assembler.sv
// rtl/program_loader_byte_assembler.sv - packs little-endian bytes into 32-bit fields
module byte_assembler
  import program_loader_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [7:0] byte_i,
  input  logic       xfer_i,
  output word_t      word_o,
  output logic       word_done_o
);

  localparam logic [1:0] LAST_IDX = 2'(BYTES_PER_WORD - 1);

  logic [1:0] cnt_q, cnt_d;
  word_t      shift_q, shift_d;

  // Bytes enter at the top and shift down, so the first byte ends up in bits 7:0.
  always_comb begin
    cnt_d   = cnt_q;
    shift_d = shift_q;
    if (xfer_i) begin
      cnt_d   = cnt_q + 2'd1;
      shift_d = {byte_i, shift_q[31:8]};
    end
  end

  assign word_o      = {byte_i, shift_q[31:8]};
  assign word_done_o = xfer_i && (cnt_q == LAST_IDX);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q   <= 2'd0;
      shift_q <= '0;
    end else begin
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
    end
  end

endmodule

// File: rtl/program_loader.sv
// rtl/program_loader.sv - loads a size-prefixed program/data byte stream into IMEM and DMEM
module program_loader
  import program_loader_pkg::*;
#(
  parameter logic [31:0] DMEM_BASE = 32'h0000_0000,
  parameter int          SIZE_W    = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [7:0]        byte_data,
  input  logic              byte_valid,
  output logic              byte_ready,
  output logic              imem_we,
  output logic [31:0]       imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              dmem_req,
  input  logic              dmem_ack,
  output logic [31:0]       dmem_addr,
  output logic [31:0]       dmem_wdata,
  output logic [SIZE_W-1:0] prog_words,
  output logic              done
);

  state_e              state_q, state_d;
  logic [SIZE_W-1:0]   idx_q, idx_d;
  logic [SIZE_W-1:0]   dcount_q, dcount_d;
  logic [SIZE_W-1:0]   prog_words_q, prog_words_d;
  logic                imem_we_q, imem_we_d;
  word_t               imem_addr_q, imem_addr_d;
  word_t               imem_wdata_q, imem_wdata_d;
  logic                dmem_req_q, dmem_req_d;
  word_t               dmem_addr_q, dmem_addr_d;
  word_t               dmem_wdata_q, dmem_wdata_d;
  logic                done_q, done_d;

  logic                xfer;
  logic                word_done;
  word_t               asm_word;
  logic [SIZE_W-1:0]   field;
  logic [SIZE_W-1:0]   idx_inc;

  assign xfer    = byte_valid && byte_ready;
  assign field   = asm_word[SIZE_W-1:0];
  assign idx_inc = idx_q + SIZE_W'(1);

  byte_assembler u_asm (
    .clk_i       (clk),
    .rst_i       (rst),
    .byte_i      (byte_data),
    .xfer_i      (xfer),
    .word_o      (asm_word),
    .word_done_o (word_done)
  );

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    dcount_d     = dcount_q;
    prog_words_d = prog_words_q;
    imem_we_d    = 1'b0;
    imem_addr_d  = imem_addr_q;
    imem_wdata_d = imem_wdata_q;
    dmem_req_d   = dmem_req_q;
    dmem_addr_d  = dmem_addr_q;
    dmem_wdata_d = dmem_wdata_q;
    done_d       = done_q;
    byte_ready   = 1'b0;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d = S_PSIZE;
          done_d  = 1'b0;
        end
      end
      S_PSIZE: begin
        byte_ready = 1'b1;
        if (word_done) begin
          prog_words_d = field;
          idx_d        = '0;
          state_d      = (field != '0) ? S_PWORD : S_DSIZE;
        end
      end
      S_PWORD: begin
        byte_ready = 1'b1;
        if (word_done) begin
          imem_we_d    = 1'b1;
          imem_addr_d  = 32'(idx_q);
          imem_wdata_d = asm_word;
          idx_d        = idx_inc;
          if (idx_inc == prog_words_q) state_d = S_DSIZE;
        end
      end
      S_DSIZE: begin
        byte_ready = 1'b1;
        if (word_done) begin
          dcount_d = field;
          idx_d    = '0;
          if (field != '0) begin
            state_d = S_DWORD;
          end else begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end
        end
      end
      S_DWORD: begin
        byte_ready = 1'b1;
        if (word_done) begin
          dmem_req_d   = 1'b1;
          dmem_addr_d  = DMEM_BASE + (32'(idx_q) << 2);
          dmem_wdata_d = asm_word;
          state_d      = S_DWAIT;
        end
      end
      S_DWAIT: begin
        // Byte intake is stalled here so the request fields cannot change under the memory.
        if (dmem_ack) begin
          dmem_req_d = 1'b0;
          idx_d      = idx_inc;
          if (idx_inc == dcount_q) begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end else begin
            state_d = S_DWORD;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      idx_q        <= '0;
      dcount_q     <= '0;
      prog_words_q <= '0;
      imem_we_q    <= 1'b0;
      imem_addr_q  <= '0;
      imem_wdata_q <= '0;
      dmem_req_q   <= 1'b0;
      dmem_addr_q  <= '0;
      dmem_wdata_q <= '0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      dcount_q     <= dcount_d;
      prog_words_q <= prog_words_d;
      imem_we_q    <= imem_we_d;
      imem_addr_q  <= imem_addr_d;
      imem_wdata_q <= imem_wdata_d;
      dmem_req_q   <= dmem_req_d;
      dmem_addr_q  <= dmem_addr_d;
      dmem_wdata_q <= dmem_wdata_d;
      done_q       <= done_d;
    end
  end

  assign imem_we    = imem_we_q;
  assign imem_addr  = imem_addr_q;
  assign imem_wdata = imem_wdata_q;
  assign dmem_req   = dmem_req_q;
  assign dmem_addr  = dmem_addr_q;
  assign dmem_wdata = dmem_wdata_q;
  assign prog_words = prog_words_q;
  assign done       = done_q;

endmodule

// File: tb/tb_program_loader.sv
// tb/tb_program_loader.sv - randomized self-checking bench for program_loader
module tb_program_loader;

  localparam logic [31:0] BASE = 32'h8000_0100;

  logic        clk = 1'b0;
  logic        rst, start, byte_valid, byte_ready, imem_we, dmem_req, dmem_ack, done;
  logic [7:0]  byte_data;
  logic [31:0] imem_addr, imem_wdata, dmem_addr, dmem_wdata;
  logic [15:0] prog_words;

  always #5 clk = ~clk;

  program_loader #(.DMEM_BASE(BASE), .SIZE_W(16)) dut (
    .clk(clk), .rst(rst), .start(start), .byte_data(byte_data), .byte_valid(byte_valid),
    .byte_ready(byte_ready), .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .dmem_req(dmem_req), .dmem_ack(dmem_ack), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .prog_words(prog_words), .done(done)
  );

  int          n_cmp = 0;
  int          n_err = 0;
  logic [7:0]  tx_q[$];
  logic [63:0] got_imem[$];
  logic [63:0] got_dmem[$];
  int          req_len[$];
  logic [31:0] p_words[$];
  logic [31:0] d_words[$];
  int          ready_bad, unstable;

  task automatic check(input string tag, input logic [159:0] obs, input logic [159:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [147:0] outs();
    return {byte_ready, imem_we, imem_addr, imem_wdata, dmem_req, dmem_addr, dmem_wdata,
            prog_words, done};
  endfunction

  task automatic push_word(input logic [31:0] w);
    tx_q.push_back(w[7:0]);
    tx_q.push_back(w[15:8]);
    tx_q.push_back(w[23:16]);
    tx_q.push_back(w[31:24]);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; start = 1'b0; byte_valid = 1'b0; dmem_ack = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic start_pulse();
    @(negedge clk);
    byte_valid = 1'b0; dmem_ack = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Drives tx_q unconditionally; only used where the loader is known to be accepting.
  task automatic feed_raw();
    while (tx_q.size() > 0) begin
      @(negedge clk);
      byte_valid = 1'b1;
      byte_data  = tx_q.pop_front();
    end
    @(negedge clk);
    byte_valid = 1'b0;
  endtask

  task automatic run(input int ack_delay, input bit hold, input bit stray, output bit ok);
    int          reqc = 0;
    logic [31:0] a0 = '0, d0 = '0;
    ok = 1'b0;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      @(negedge clk);
      if (imem_we) got_imem.push_back({imem_addr, imem_wdata});
      dmem_ack = 1'b0;
      if (dmem_req) begin
        if (reqc == 0) begin
          a0 = dmem_addr; d0 = dmem_wdata;
        end else if (dmem_addr !== a0 || dmem_wdata !== d0) begin
          unstable++;
        end
        if (byte_ready) ready_bad++;
        reqc++;
        if (reqc >= ack_delay) begin
          dmem_ack = 1'b1;
          got_dmem.push_back({dmem_addr, dmem_wdata});
          req_len.push_back(reqc);
          reqc = 0;
        end
      end else begin
        dmem_ack = stray && ($urandom_range(0, 3) == 0);
      end
      if (tx_q.size() == 0 && done && !dmem_req) begin
        byte_valid = 1'b0; dmem_ack = 1'b0; ok = 1'b1;
        break;
      end
      byte_valid = 1'b0;
      byte_data  = 8'($urandom);
      if (tx_q.size() > 0 && (hold || $urandom_range(0, 2) != 0)) begin
        byte_valid = 1'b1;
        byte_data  = tx_q[0];
        if (byte_ready) void'(tx_q.pop_front());
      end
    end
  endtask

  task automatic session(input string tag, input int ack_delay, input bit hold, input bit stray,
                         input logic [15:0] p_hi, input logic [15:0] d_hi);
    logic [63:0] exp_i[$];
    logic [63:0] exp_d[$];
    bit          ok;
    tx_q.delete(); got_imem.delete(); got_dmem.delete(); req_len.delete();
    ready_bad = 0; unstable = 0;
    push_word({p_hi, 16'(p_words.size())});
    foreach (p_words[i]) push_word(p_words[i]);
    push_word({d_hi, 16'(d_words.size())});
    foreach (d_words[i]) push_word(d_words[i]);
    foreach (p_words[i]) exp_i.push_back({32'(i), p_words[i]});
    foreach (d_words[i]) exp_d.push_back({BASE + 32'(4 * i), d_words[i]});
    start_pulse();
    check({tag, "_done_clr"}, done, 1'b0);
    run(ack_delay, hold, stray, ok);
    check({tag, "_timeout"}, ok, 1'b1);
    check({tag, "_imem_n"}, got_imem.size(), exp_i.size());
    for (int i = 0; i < exp_i.size(); i++)
      check($sformatf("%s_imem%0d", tag, i), (i < got_imem.size()) ? got_imem[i] : 64'hx, exp_i[i]);
    check({tag, "_dmem_n"}, got_dmem.size(), exp_d.size());
    for (int i = 0; i < exp_d.size(); i++)
      check($sformatf("%s_dmem%0d", tag, i), (i < got_dmem.size()) ? got_dmem[i] : 64'hx, exp_d[i]);
    check({tag, "_prog_words"}, prog_words, 16'(p_words.size()));
    check({tag, "_done"}, done, 1'b1);
    check({tag, "_ready_in_wait"}, ready_bad, 0);
    check({tag, "_req_stable"}, unstable, 0);
  endtask

  initial begin
    int bad;
    rst = 1'b1; start = 1'b0; byte_valid = 1'b0; byte_data = 8'h00; dmem_ack = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("reset_outs", outs(), '0);

    bad = 0;
    repeat (4) begin
      @(negedge clk);
      byte_valid = 1'b1; byte_data = 8'($urandom);
      if ({byte_ready, imem_we, dmem_req, done} !== 4'b0000) bad++;
    end
    @(negedge clk);
    byte_valid = 1'b0;
    check("idle_bytes", {bad, outs()}, '0);

    p_words = '{32'h1234_5678, 32'hDEAD_BEEF}; d_words.delete();
    session("prog2", 1, 1'b1, 1'b0, 16'h0, 16'h0);

    bad = 0;
    repeat (4) begin
      @(negedge clk);
      byte_valid = 1'b1; byte_data = 8'($urandom);
      if ({byte_ready, imem_we, dmem_req, done} !== 4'b0001) bad++;
    end
    @(negedge clk);
    byte_valid = 1'b0;
    check("done_bytes", bad, 0);

    p_words.delete(); d_words = '{32'h1122_3344};
    session("data1", 5, 1'b1, 1'b0, 16'h0, 16'h0);
    check("data1_reqlen", (req_len.size() > 0) ? req_len[0] : -1, 5);

    p_words.delete(); d_words = '{32'hCAFE_0001, 32'h0BAD_F00D};
    session("data2", 3, 1'b1, 1'b0, 16'h0, 16'h0);

    start_pulse();
    tx_q.delete();
    push_word(32'd2); tx_q.push_back(8'hAA); tx_q.push_back(8'hBB);
    feed_raw();
    check("mid_prog_no_we", imem_we, 1'b0);
    do_reset();
    check("rst_mid_prog", outs(), '0);
    p_words = '{32'hA5A5_0000, 32'h0000_5A5A, 32'hFFFF_FFFF}; d_words = '{32'h7777_8888};
    session("after_rst", 2, 1'b0, 1'b1, 16'h0, 16'h0);

    start_pulse();
    tx_q.delete();
    push_word(32'd0); push_word(32'd1); push_word(32'h4433_2211);
    feed_raw();
    check("dwait_req", {dmem_req, dmem_wdata}, {1'b1, 32'h4433_2211});
    do_reset();
    check("rst_in_dwait", outs(), '0);
    bad = 0;
    repeat (6) begin
      @(negedge clk);
      if (dmem_req || imem_we) bad++;
    end
    check("no_req_after_rst", bad, 0);

    start_pulse();
    tx_q.delete();
    push_word(32'h0001_FFFF);
    feed_raw();
    check("psize_trunc", {prog_words, byte_ready}, {16'hFFFF, 1'b1});
    do_reset();

    for (int s = 0; s < 6; s++) begin
      p_words.delete(); d_words.delete();
      repeat ($urandom_range(0, 5)) p_words.push_back($urandom);
      repeat ($urandom_range(0, 4)) d_words.push_back($urandom);
      session($sformatf("rnd%0d", s), $urandom_range(1, 4), 1'($urandom_range(0, 1)), 1'b1,
              16'($urandom), 16'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
